// File: rtl/mem_0_pkg.sv
// Shared definitions for the first memory stage.
// Fault cause codes, default address width and the Mem_0 -> Mem_1 bundle.
package mem_0_pkg;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;
    localparam logic [1:0] FAULT_BOTH     = 2'b11;

    localparam int DATA_ADDR_BITS = 9;

    typedef struct packed {
        logic        oper;
        logic        readmem;
        logic        writemem;
        logic        writereg;
        logic [31:0] data_addr;
        logic [31:0] regb;
        logic [4:0]  regdest;
    } m0_m1_t;

    function automatic logic [1:0] fault_cause(
        input logic misaligned,
        input logic out_of_range
    );
        logic [1:0] c;
        c = FAULT_NONE;
        if (misaligned)   c = c | FAULT_MISALIGN;
        if (out_of_range) c = c | FAULT_RANGE;
        return c;
    endfunction

endpackage

// File: rtl/mem_0_addr_check.sv
// Effective address generation and access checks for Mem_0.
// Purely combinational; the EA wraps modulo 2^32.
module mem_addr_check #(
    parameter int ADDR_BITS = 9
) (
    input  logic [31:0] rega,
    input  logic [31:0] imm,
    input  logic        readmem,
    input  logic        writemem,
    output logic [31:0] ea,
    output logic        misaligned,
    output logic        out_of_range
);

    logic mem_op;

    always_comb begin
        ea           = rega + imm;
        mem_op       = readmem | writemem;
        misaligned   = mem_op & (ea[1:0] != 2'b00);
        out_of_range = mem_op & (ea[31:ADDR_BITS] != '0);
    end

endmodule

// File: rtl/mem_0.sv
// First memory stage: computes EA, checks it and registers the op
// onto the m0_m1 bus, with a sticky fault record and activity counters.
module mem_0
    import mem_0_pkg::*;
#(
    parameter int ADDR_BITS = DATA_ADDR_BITS,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iss_m0_oper,
    input  logic             iss_m0_readmem,
    input  logic             iss_m0_writemem,
    input  logic [31:0]      iss_m0_rega,
    input  logic [31:0]      iss_m0_imm,
    input  logic [31:0]      iss_m0_regb,
    input  logic [4:0]       iss_m0_regdest,
    input  logic             iss_m0_writereg,
    input  logic             m0_stall,
    input  logic             m0_flush,
    input  logic             m0_fault_clear,
    output logic             m0_m1_oper,
    output logic             m0_m1_readmem,
    output logic             m0_m1_writemem,
    output logic             m0_m1_writereg,
    output logic [31:0]      m0_m1_data_addr,
    output logic [31:0]      m0_m1_regb,
    output logic [4:0]       m0_m1_regdest,
    output logic             m0_fault,
    output logic [1:0]       m0_fault_cause,
    output logic [31:0]      m0_fault_addr,
    output logic [CNT_W-1:0] m0_load_count,
    output logic [CNT_W-1:0] m0_store_count
);

    logic [31:0] ea;
    logic        misaligned;
    logic        out_of_range;

    mem_addr_check #(
        .ADDR_BITS (ADDR_BITS)
    ) u_check (
        .rega         (iss_m0_rega),
        .imm          (iss_m0_imm),
        .readmem      (iss_m0_readmem),
        .writemem     (iss_m0_writemem),
        .ea           (ea),
        .misaligned   (misaligned),
        .out_of_range (out_of_range)
    );

    m0_m1_t          bus_d,       bus_q;
    logic            fault_d,     fault_q;
    logic [1:0]      cause_d,     cause_q;
    logic [31:0]     faddr_d,     faddr_q;
    logic [CNT_W-1:0] ld_cnt_d,   ld_cnt_q;
    logic [CNT_W-1:0] st_cnt_d,   st_cnt_q;

    logic advance;
    logic fault;
    logic take;
    logic take_fault;

    always_comb begin
        advance    = ~m0_flush & ~m0_stall;
        fault      = iss_m0_oper & (misaligned | out_of_range);
        take       = advance & iss_m0_oper & ~fault;
        take_fault = advance & fault;
    end

    always_comb begin
        bus_d = bus_q;
        if (m0_flush) begin
            bus_d = '0;
        end else if (!m0_stall) begin
            bus_d = '0;
            if (take) begin
                bus_d.oper      = 1'b1;
                bus_d.readmem   = iss_m0_readmem;
                bus_d.writemem  = iss_m0_writemem;
                bus_d.writereg  = iss_m0_writereg;
                bus_d.data_addr = ea;
                bus_d.regb      = iss_m0_regb;
                bus_d.regdest   = iss_m0_regdest;
            end
        end
    end

    // A new fault in the same cycle as a clear is recorded: set wins.
    always_comb begin
        fault_d = fault_q;
        cause_d = cause_q;
        faddr_d = faddr_q;
        if (m0_fault_clear) begin
            fault_d = 1'b0;
            cause_d = FAULT_NONE;
            faddr_d = '0;
        end
        if (take_fault && (!fault_q || m0_fault_clear)) begin
            fault_d = 1'b1;
            cause_d = fault_cause(misaligned, out_of_range);
            faddr_d = ea;
        end
    end

    // Read+write together counts as a load.
    always_comb begin
        ld_cnt_d = ld_cnt_q;
        st_cnt_d = st_cnt_q;
        if (take && iss_m0_readmem) begin
            ld_cnt_d = ld_cnt_q + CNT_W'(1);
        end else if (take && iss_m0_writemem) begin
            st_cnt_d = st_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_q    <= '0;
            fault_q  <= 1'b0;
            cause_q  <= FAULT_NONE;
            faddr_q  <= '0;
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
        end else begin
            bus_q    <= bus_d;
            fault_q  <= fault_d;
            cause_q  <= cause_d;
            faddr_q  <= faddr_d;
            ld_cnt_q <= ld_cnt_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    always_comb begin
        m0_m1_oper      = bus_q.oper;
        m0_m1_readmem   = bus_q.readmem;
        m0_m1_writemem  = bus_q.writemem;
        m0_m1_writereg  = bus_q.writereg;
        m0_m1_data_addr = bus_q.data_addr;
        m0_m1_regb      = bus_q.regb;
        m0_m1_regdest   = bus_q.regdest;
        m0_fault        = fault_q;
        m0_fault_cause  = cause_q;
        m0_fault_addr   = faddr_q;
        m0_load_count   = ld_cnt_q;
        m0_store_count  = st_cnt_q;
    end

endmodule

// File: doc/mem_0.md
Name: mem_0

Overview:
- First memory stage, directly upstream of Mem_1.
- Takes issued memory ops and computes the effective address (base + immediate).
- Checks alignment and data-memory range, then registers the result onto the m0_m1_* bus that Mem_1 consumes.
- Also supports stall/flush, a sticky fault record for bad accesses, and load/store activity counters.

Parameters:
- ADDR_BITS, 9: byte-address width of data memory (128 words); EA bits above this must be zero.
- CNT_W, 16: width of load/store counters.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- iss_m0_oper  in  1  valid op present
- iss_m0_readmem  in  1  load
- iss_m0_writemem  in  1  store
- iss_m0_rega  in  32  base register value
- iss_m0_imm  in  32  sign-extended offset
- iss_m0_regb  in  32  store data
- iss_m0_regdest  in  5  destination register
- iss_m0_writereg  in  1  register write-back enable
- m0_stall  in  1  hold stage contents
- m0_flush  in  1  squash incoming op
- m0_fault_clear  in  1  clear sticky fault
- m0_m1_oper, m0_m1_readmem, m0_m1_writemem, m0_m1_writereg  out  1 each  registered to Mem_1
- m0_m1_data_addr  out  32  registered effective address
- m0_m1_regb  out  32  registered store data
- m0_m1_regdest  out  5  registered destination
- m0_fault  out  1  sticky fault flag
- m0_fault_cause  out  2  01 misaligned, 10 out of range, 11 both
- m0_fault_addr  out  32  EA of first fault
- m0_load_count, m0_store_count  out  CNT_W  accepted loads / stores

Behaviour:
- Reset (reset low, asynchronous): every output register is 0, including the fault record and counters.
- EA = iss_m0_rega + iss_m0_imm, 32-bit, wraps modulo 2^32; carry is discarded.
- mem_op = iss_m0_readmem | iss_m0_writemem.
- misaligned = mem_op & (EA[1:0] != 0).
- out_of_range = mem_op & (EA[31:ADDR_BITS] != 0).
- fault = iss_m0_oper & (misaligned | out_of_range).
- Op type: readmem=1 and writemem=1 together is classed as a load. The flags pass through unchanged, and Mem_1 treats it as a read.
- Non-memory ops (mem_op=0, oper=1) pass through with writereg/regdest; no checks are applied.
- Latency: one cycle, issue to m0_m1_*.
- Per-posedge priority, highest first:
  1. m0_flush=1: bubble (all m0_m1_* = 0); no fault latched, no count. Flush beats stall.
  2. m0_stall=1: all m0_m1_* hold; no fault latched, no count.
  3. iss_m0_oper=0: bubble.
  4. fault=1: bubble; the fault is latched per the sticky-fault rules below.
  5. Otherwise: load all m0_m1_* from the inputs/EA; m0_m1_oper=1.
- Bubble: oper, readmem, writemem and writereg all 0; data_addr, regb and regdest also 0.
- Sticky fault:
  - When m0_fault=0 and a fault is accepted: set m0_fault=1 and latch cause and EA.
  - Later faults while m0_fault=1 are dropped; the first fault wins.
  - m0_fault_clear=1 clears all three fault outputs.
  - If clear and a new fault occur in the same cycle, the new fault is recorded (set wins).
- Counters:
  - m0_load_count increments when case 5 is taken with readmem=1.
  - m0_store_count increments when case 5 is taken with readmem=0 and writemem=1.
  - Both wrap at 2^CNT_W; no saturation.
- Reset asserted mid-stall or mid-fault returns everything to 0 immediately; no op survives.

Decomposition:
- Shared header mem_defs.v, with include guard, holding:
  - fault cause codes FAULT_NONE=2'b00, FAULT_MISALIGN=2'b01, FAULT_RANGE=2'b10, FAULT_BOTH=2'b11;
  - default DATA_ADDR_BITS=9.
- One natural sub-module: mem_addr_check. It is purely combinational: inputs rega, imm, readmem, writemem; outputs EA, misaligned, out_of_range.
- Registers, priority logic, fault record and counters stay in mem_0.

Test Plan:
- Load pass-through: rega=0x40, imm=0x4, readmem=1, writereg=1, regdest=5 → next cycle data_addr=0x44, oper=1, regdest=5, load_count=1, fault=0.
- Misaligned store: rega=0x40, imm=0x2, writemem=1 → bubble (oper=0), fault=1, cause=01, fault_addr=0x42, store_count=0. A second fault at 0x201 afterwards leaves fault_addr at 0x42.
- Range + wrap: rega=0xFFFF_FFFC, imm=0x8 → EA=0x4, accepted with data_addr=0x4. Then rega=0x200, imm=0 → cause=10. After clear, EA=0x203 → cause=11.
- Stall/flush:
  - Valid store to 0x10, then stall=1 for 3 cycles with different inputs → m0_m1_* hold 0x10 and store_count stays 1.
  - Then stall=1 and flush=1 together → bubble.
- Clear vs set: fault=1; assert fault_clear in the same cycle as a misaligned load at 0x6 → fault=1, fault_addr=0x6, cause=01.
- Async reset: drop reset mid-cycle with valid outputs and fault=1 → all outputs 0 before the next clock edge; counters 0 after release.
